sd_card_cpu_debug_ocimem: RTL
=============================

SD_CARD_CPU_DEBUG_OCIMEM -- requirements
Module: sd_card_cpu_debug_ocimem

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset: clk (all logic on rising edge), reset_n (async assert, sync deassert, active low).
REQ-002 SHALL have port clk, input, 1 bit: system clock.
REQ-003 SHALL have port reset_n, input, 1 bit: async active-low reset.
REQ-004 SHALL have port jdo, input, 38 bits: JTAG data register, valid in sysclk domain during take_* pulses.
REQ-005 SHALL have ports take_action_ocimem_a, take_action_ocimem_b and take_no_action_ocimem_a, each input, 1 bit: single-cycle JTAG command pulses.
REQ-006 SHALL have port address, input, 8 bits: CPU word address.
REQ-007 SHALL have ports read, write and debugaccess, each input, 1 bit: CPU slave controls.
REQ-008 SHALL have port byteenable, input, 4 bits.
REQ-009 SHALL have port writedata, input, 32 bits.
REQ-010 SHALL have port readdata, output, 32 bits.
REQ-011 SHALL have port waitrequest, output, 1 bit.
REQ-012 SHALL have port MonDReg, output, 32 bits: JTAG monitor data register.
REQ-013 SHALL have port monitor_ready, output, 1 bit: JTAG access complete.
REQ-014 SHALL have port monitor_error, output, 1 bit: sticky error.

Function
REQ-015 SHALL hold a 256x32 debug RAM with a 1-cycle registered read.
REQ-016 take_action_ocimem_a SHALL load MonAReg<=jdo[25:18], clear monitor_ready and monitor_error, and issue a JTAG read if jdo[17]=1.
REQ-017 take_no_action_ocimem_a SHALL issue a JTAG read at MonAReg, then post-increment MonAReg.
REQ-018 take_action_ocimem_b SHALL load MonDReg<=jdo[34:3], write the full word to MonAReg, then post-increment MonAReg.
REQ-019 MonAReg increment SHALL wrap from 255 to 0.
REQ-020 FSM states SHALL be IDLE, JRD, JRD_CAP, JWR, CRD, CRD_CAP, CWR.
REQ-021 JTAG read path SHALL be IDLE->JRD (RAM addressed)->JRD_CAP (MonDReg<=RAM data, monitor_ready<=1)->IDLE, giving 2 cycles pulse-to-ready.
REQ-022 JTAG write path SHALL be IDLE->JWR (RAM write)->IDLE, with monitor_ready<=1 on exit.
REQ-023 CPU read path SHALL be IDLE->CRD->CRD_CAP (readdata valid, waitrequest=0)->IDLE.
REQ-024 waitrequest SHALL be 1 whenever read|write is asserted and the access is not in its completing cycle.
REQ-025 CPU write SHALL complete in CWR with waitrequest=0 and per-byte byteenable.
REQ-026 A CPU write with debugaccess=0 SHALL be acknowledged without modifying the RAM and SHALL set monitor_error.
REQ-027 A JTAG pulse and a CPU request in the same IDLE cycle SHALL resolve with JTAG winning; the CPU waits, waitrequest stays 1.
REQ-028 A JTAG pulse arriving while the FSM is not IDLE SHALL be latched in a one-entry pending slot, with opcode and jdo captured.
REQ-029 A pending JTAG access SHALL be served on the next IDLE before any CPU request.
REQ-030 A JTAG pulse arriving while the pending slot is full SHALL be dropped and SHALL set monitor_error.
REQ-031 read and write asserted together SHALL be treated as a read.

Reset
REQ-032 On reset_n=0, the state SHALL go to IDLE asynchronously.
REQ-033 On reset_n=0, MonAReg, MonDReg, readdata and the pending slot SHALL clear to 0.
REQ-034 On reset_n=0, monitor_ready, monitor_error and waitrequest SHALL be 0.
REQ-035 RAM contents SHALL be unaffected by reset.
REQ-036 Reset mid-access SHALL abort the access; an in-flight write either completes or does not occur, with no partial byte lanes.

Structure
REQ-037 Shared package sd_card_cpu_debug_pkg SHALL hold the FSM state enum, the RAM depth and address width constants (256, 8), and the jdo field positions (addr 25:18, rd 17, data 34:3).
REQ-038 The RAM SHALL be one sub-module, sd_card_cpu_debug_ram: single-port, 256x32, byte enables, registered read.

Verification
REQ-039 SHALL test JTAG write then read-back: take_action_ocimem_a with jdo[25:18]=8'h10 and jdo[17]=0, then take_action_ocimem_b with data 32'hDEADBEEF, then take_action_ocimem_a with addr 8'h10 and rd=1 -> MonDReg=32'hDEADBEEF and monitor_ready=1 two cycles after the pulse.
REQ-040 SHALL test auto-increment wrap: MonAReg=8'hFF, then two take_no_action_ocimem_a pulses -> reads from 0xFF then 0x00.
REQ-041 SHALL test CPU byte write: write addr 8'h20, byteenable 4'b0010, writedata 32'h0000AB00, debugaccess=1 over a word of 0 -> CPU read returns 32'h0000AB00, waitrequest=0 only in CRD_CAP.
REQ-042 SHALL test collision: CPU read and take_action_ocimem_a (rd=1) in the same cycle -> JTAG completes first, CPU readdata valid no earlier than 4 cycles later.
REQ-043 SHALL test overflow and protection: three JTAG pulses on consecutive cycles -> third dropped, monitor_error=1; a CPU write with debugaccess=0 -> RAM unchanged, monitor_error=1.
REQ-044 SHALL test reset mid-JTAG-read: reset_n low in JRD -> all outputs 0, state IDLE, prior RAM contents intact.

Source files
------------

// File: rtl/sd_card_cpu_debug_pkg.sv
// Shared types and constants for the CPU debug on-chip memory: FSM states,
// RAM geometry, JTAG command encoding and the jdo field layout.
package sd_card_cpu_debug_pkg;

  localparam int RAM_DEPTH    = 256;
  localparam int RAM_AW       = 8;

  localparam int JDO_W        = 38;
  localparam int JDO_ADDR_LSB = 18;
  localparam int JDO_ADDR_MSB = 25;
  localparam int JDO_RD_BIT   = 17;
  localparam int JDO_DATA_LSB = 3;
  localparam int JDO_DATA_MSB = 34;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_JRD,
    ST_JRD_CAP,
    ST_JWR,
    ST_CRD,
    ST_CRD_CAP,
    ST_CWR
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_ACT_A,
    OP_NOACT_A,
    OP_ACT_B
  } jop_t;

  // A decoded JTAG command, as held in the one-entry pending slot.
  typedef struct packed {
    jop_t              op;
    logic [RAM_AW-1:0] addr;
    logic              rd;
    logic [31:0]       data;
  } jcmd_t;

endpackage

// File: rtl/sd_card_cpu_debug_ocimem_if.sv
// CPU slave bus of the debug memory (Avalon-style read/write with waitrequest).
interface sd_card_cpu_debug_ocimem_if;
  import sd_card_cpu_debug_pkg::*;

  logic [RAM_AW-1:0] address;
  logic              read;
  logic              write;
  logic              debugaccess;
  logic [3:0]        byteenable;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              waitrequest;

  modport master (
    output address, read, write, debugaccess, byteenable, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, read, write, debugaccess, byteenable, writedata,
    output readdata, waitrequest
  );

endinterface

// File: rtl/sd_card_cpu_debug_ram.sv
// Single-port 256x32 debug RAM with per-byte write enables and a registered read.
module sd_card_cpu_debug_ram
  import sd_card_cpu_debug_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [RAM_AW-1:0] addr,
  input  logic              rd_en,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  output logic [31:0]       q
);

  logic [31:0] mem [RAM_DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM and keeps its
  // contents across reset; only the output register below is cleared.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   q <= '0;
    else if (rd_en) q <= mem[addr];
  end

endmodule

// File: rtl/sd_card_cpu_debug_ocimem.sv
// Debug on-chip memory shared by the JTAG monitor and the CPU slave port.
// JTAG accesses win arbitration; one extra JTAG command may wait in a pending slot.
module sd_card_cpu_debug_ocimem
  import sd_card_cpu_debug_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [JDO_W-1:0]          jdo,
  input  logic                      take_action_ocimem_a,
  input  logic                      take_action_ocimem_b,
  input  logic                      take_no_action_ocimem_a,
  sd_card_cpu_debug_ocimem_if.slave bus,
  output logic [31:0]               MonDReg,
  output logic                      monitor_ready,
  output logic                      monitor_error
);

  state_t            state, state_next;
  jcmd_t             new_cmd, pend, cmd;
  logic              new_valid, pend_valid, serve, drop;
  logic [RAM_AW-1:0] mon_a, j_addr, ram_addr;
  logic              ram_rd;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata, ram_q;
  logic              unused_jdo;

  assign unused_jdo = ^{jdo[JDO_W-1:JDO_DATA_MSB+1], jdo[JDO_DATA_LSB-1:0]};

  always_comb begin
    new_cmd.addr = jdo[JDO_ADDR_MSB:JDO_ADDR_LSB];
    new_cmd.rd   = jdo[JDO_RD_BIT];
    new_cmd.data = jdo[JDO_DATA_MSB:JDO_DATA_LSB];
    if      (take_action_ocimem_a)    new_cmd.op = OP_ACT_A;
    else if (take_no_action_ocimem_a) new_cmd.op = OP_NOACT_A;
    else if (take_action_ocimem_b)    new_cmd.op = OP_ACT_B;
    else                              new_cmd.op = OP_NONE;
  end

  assign new_valid = (new_cmd.op != OP_NONE);
  assign cmd       = pend_valid ? pend : new_cmd;
  assign drop      = new_valid && pend_valid && (state != ST_IDLE);

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    serve      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pend_valid || new_valid) begin
          serve = 1'b1;
          case (cmd.op)
            OP_ACT_A:   if (cmd.rd) state_next = ST_JRD;
            OP_NOACT_A: state_next = ST_JRD;
            OP_ACT_B:   state_next = ST_JWR;
            default:    state_next = ST_IDLE;
          endcase
        end else if (bus.read) begin
          state_next = ST_CRD;
        end else if (bus.write) begin
          state_next = ST_CWR;
        end
      end
      ST_JRD:     state_next = ST_JRD_CAP;
      ST_CRD:     state_next = ST_CRD_CAP;
      ST_JRD_CAP,
      ST_JWR,
      ST_CRD_CAP,
      ST_CWR:     state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // A single RAM port is shared; each write is one clock edge, so a reset
  // can never leave part of a word written.
  always_comb begin
    ram_addr  = j_addr;
    ram_rd    = 1'b0;
    ram_be    = 4'h0;
    ram_wdata = MonDReg;
    case (state)
      ST_JRD: ram_rd = 1'b1;
      ST_JWR: ram_be = 4'hF;
      ST_CRD: begin
        ram_addr = bus.address;
        ram_rd   = 1'b1;
      end
      ST_CWR: begin
        ram_addr  = bus.address;
        ram_wdata = bus.writedata;
        ram_be    = bus.debugaccess ? bus.byteenable : 4'h0;
      end
      default: ;
    endcase
  end

  sd_card_cpu_debug_ram u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .addr    (ram_addr),
    .rd_en   (ram_rd),
    .be      (ram_be),
    .wdata   (ram_wdata),
    .q       (ram_q)
  );

  assign bus.readdata    = ram_q;
  assign bus.waitrequest = reset_n && (bus.read || bus.write) &&
                           (state != ST_CRD_CAP) && (state != ST_CWR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mon_a         <= '0;
      j_addr        <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
      pend          <= '0;
      pend_valid    <= 1'b0;
    end else begin
      if (serve) begin
        monitor_ready <= 1'b0;
        case (cmd.op)
          OP_ACT_A: begin
            mon_a         <= cmd.addr;
            j_addr        <= cmd.addr;
            monitor_error <= 1'b0;
          end
          OP_NOACT_A: begin
            j_addr <= mon_a;
            mon_a  <= mon_a + 1'b1;
          end
          OP_ACT_B: begin
            j_addr  <= mon_a;
            mon_a   <= mon_a + 1'b1;
            MonDReg <= cmd.data;
          end
          default: ;
        endcase
      end
      if (state == ST_JRD_CAP) begin
        MonDReg       <= ram_q;
        monitor_ready <= 1'b1;
      end
      if (state == ST_JWR) monitor_ready <= 1'b1;
      if (drop || (state == ST_CWR && !bus.debugaccess)) monitor_error <= 1'b1;

      // In IDLE the slot drains and can refill from a pulse in the same cycle.
      if (new_valid && ((state == ST_IDLE) ? pend_valid : !pend_valid)) begin
        pend       <= new_cmd;
        pend_valid <= 1'b1;
      end else if (state == ST_IDLE && pend_valid) begin
        pend_valid <= 1'b0;
      end
    end
  end

endmodule
